// File: rtl/imem_loader.sv
// Framed byte-stream loader for the 128-word instruction memory.
// Holds the core in reset until a frame's XOR checksum verifies.
module imem_loader #(
  parameter int N  = 32,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [N-1:0]  mem_wdata,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
    S_CHECK,
    S_DONE
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] cnt, cnt_n;
  logic [AW-1:0] idx, idx_n;
  logic [1:0]    lane, lane_n;
  logic [7:0]    acc, acc_n;
  logic [23:0]   wbuf, wbuf_n;
  logic          we_n;
  logic [AW-1:0] addr_n;
  logic [N-1:0]  wdata_n;
  logic          hold_n, busy_n, done_n, err_n;
  logic          fire;

  assign in_ready = (state == S_COUNT) ||
                    (state == S_DATA)  ||
                    (state == S_CHECK);
  assign fire = in_valid & in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      lane      <= '0;
      acc       <= '0;
      wbuf      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      lane      <= lane_n;
      acc       <= acc_n;
      wbuf      <= wbuf_n;
      mem_we    <= we_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      cpu_hold  <= hold_n;
      busy      <= busy_n;
      done      <= done_n;
      err       <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    lane_n  = lane;
    acc_n   = acc;
    wbuf_n  = wbuf;
    we_n    = 1'b0;
    addr_n  = mem_addr;
    wdata_n = mem_wdata;
    hold_n  = cpu_hold;
    done_n  = 1'b0;
    err_n   = err;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_COUNT;
          hold_n  = 1'b1;
          err_n   = 1'b0;
          idx_n   = '0;
          lane_n  = '0;
          acc_n   = '0;
        end
      end
      S_COUNT: begin
        if (fire) begin
          cnt_n   = in_data[AW-1:0];
          acc_n   = in_data;
          state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (fire) begin
          acc_n  = acc ^ in_data;
          lane_n = lane + 2'd1;
          unique case (lane)
            2'd0: wbuf_n[7:0]   = in_data;
            2'd1: wbuf_n[15:8]  = in_data;
            2'd2: wbuf_n[23:16] = in_data;
            2'd3: begin
              we_n    = 1'b1;
              addr_n  = idx;
              wdata_n = {in_data, wbuf};
              idx_n   = idx + 1'b1;
              // idx wraps only after word 127, when we leave DATA anyway
              if (idx == cnt) state_n = S_CHECK;
            end
          endcase
        end
      end
      S_CHECK: begin
        if (fire) begin
          done_n  = 1'b1;
          state_n = S_DONE;
          if (in_data == acc) hold_n = 1'b0;
          else                err_n  = 1'b1;
        end
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n != S_IDLE);
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized bench for imem_loader against a frame-level
// model: expected writes and checksum verdict computed from the image.
`timescale 1ns/1ps
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;

  imem_loader #(.N(32), .AW(7)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;
  int cyc   = 0;
  logic [31:0] img [128];
  logic [6:0]  wa [$];
  logic [31:0] wd [$];
  int          wc [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (mem_we === 1'b1) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
      wc.push_back(cyc);
    end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_cpu_hold"}, cpu_hold, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  task automatic clear_cap();
    wa.delete(); wd.delete(); wc.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_hold", cpu_hold, 1);
    check("start_err_clr", err, 0);
  endtask

  // Offer one byte; returns at the negedge after it was accepted.
  task automatic push(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("push_timeout", t, 0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input int nw, input bit bad, input bit gaps,
                           input int start_at, input bit timing);
    logic [7:0] q [$];
    logic [7:0] x;
    q.push_back(8'(nw - 1));
    for (int i = 0; i < nw; i++)
      for (int k = 0; k < 4; k++)
        q.push_back(img[i][8*k +: 8]);
    x = '0;
    foreach (q[j]) x ^= q[j];
    q.push_back(bad ? ((x == 8'h00) ? 8'hff : 8'h00) : x);
    clear_cap();
    pulse_start();
    foreach (q[j]) begin
      if (j == start_at) start = 1'b1;
      push(q[j], gaps);
      start = 1'b0;
    end
    check("done_pulse", done, 1);
    check("done_err", err, 32'(bad));
    check("done_hold", cpu_hold, 32'(bad));
    @(negedge clk);
    check("done_low", done, 0);
    check("idle_busy", busy, 0);
    @(negedge clk);
    check("write_count", wa.size(), nw);
    for (int i = 0; i < nw && i < wa.size(); i++) begin
      check($sformatf("addr%0d", i), wa[i], i);
      check($sformatf("data%0d", i), wd[i], img[i]);
      if (timing && i > 0)
        check($sformatf("spacing%0d", i), wc[i] - wc[i-1], 4);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    reset_n = 1'b1;
    @(negedge clk);
    chk_reset("post_rst");

    img[0] = 32'hf8000001;
    run_frame(1, 0, 0, -1, 0);
    run_frame(1, 1, 0, -1, 0);
    run_frame(1, 0, 0, -1, 0);

    for (int i = 0; i < 128; i++) img[i] = 32'h8b1f0000 + i;
    run_frame(128, 0, 0, -1, 1);

    for (int i = 0; i < 3; i++) img[i] = $urandom;
    run_frame(3, 0, 0, -1, 1);
    run_frame(3, 0, 1, -1, 0);
    run_frame(3, 0, 0, 6, 1);

    for (int i = 0; i < 3; i++) img[i] = $urandom;
    clear_cap();
    pulse_start();
    push(8'd2, 0);
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++)
        push(img[i][8*k +: 8], 0);
    @(negedge clk);
    check("mid_writes", wa.size(), 2);
    #2 reset_n = 1'b0;
    #1 chk_reset("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk_reset("midrst_rel");
    run_frame(3, 0, 0, -1, 1);

    for (int f = 0; f < 6; f++) begin
      int nw;
      nw = $urandom_range(1, 8);
      for (int i = 0; i < nw; i++) img[i] = $urandom;
      run_frame(nw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                -1, 0);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream program loader that writes the processor's 128-word instruction memory at run time, replacing hard-coded ROM images. It accepts a framed byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and drives the write port of a writable instruction memory. It holds the pipeline in reset while loading and releases it only after the frame checksum verifies.

## Interface
- N, 32, instruction word width (fixed at 32; byte assembly assumes N = 32)
- AW, 7, instruction memory address width (128 words)
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin a load frame; sampled only in IDLE
- in_valid  in  1  in_data is valid this cycle
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  instruction memory write enable, one-cycle pulse per word
- mem_addr  out  AW  word address of the write
- mem_wdata  out  N  instruction word being written
- cpu_hold  out  1  holds the processor in reset while high
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a frame ends (checksum good or bad)
- err  out  1  checksum mismatch on the last frame; sticky until the next accepted start

## Operation
- Frame layout: COUNT byte c (words = c+1, range 1..128), then 4·(c+1) data bytes, then one CHK byte.
- A byte is accepted when in_valid & in_ready.
- Data bytes are little-endian: byte k (k = 0..3) of a word goes to bits [8k+7:8k].
- Checksum is the XOR of the COUNT byte and all data bytes. A frame passes if CHK equals that XOR.
- IDLE:
  - in_ready = 0.
  - start -> COUNT. On this transition: cpu_hold = 1, err = 0, word index = 0, byte lane = 0, xor accumulator = 0.
- COUNT:
  - in_ready = 1.
  - On accept: latch c, set xor = in_data, go to DATA.
- DATA:
  - in_ready = 1.
  - On accept: place the byte in the current lane, XOR it into the accumulator, and advance the lane.
  - On accepting lane 3, schedule a write of the assembled word to the current word index, then increment the index.
  - After lane 3 of word c is accepted, go to CHECK.
- CHECK:
  - in_ready = 1.
  - On accept, compare the byte to the accumulator and go to DONE.
- DONE (single cycle):
  - done = 1, then go to IDLE.
  - On match: cpu_hold -> 0 and err stays 0.
  - On mismatch: err -> 1 and cpu_hold stays 1, so the processor is never released on a corrupt image.
- start is ignored while busy. start in IDLE with err = 1 re-runs a full load.
- The word index never exceeds c, so the maximum address is 127 and there is no wrap.
- No mem_we is issued outside DATA, including for the COUNT and CHK bytes.

## Timing
- Reset values:
  - in_ready = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - cpu_hold = 0, busy = 0, done = 0, err = 0.
  - State = IDLE.
- All outputs are registered, except in_ready, which is decoded from state.
- busy and cpu_hold rise the cycle after start is sampled in IDLE.
- mem_we pulses for exactly one cycle, the cycle after lane 3 is accepted. mem_addr and mem_wdata are valid in that same cycle and hold their values until the next write.
- in_ready never deasserts inside DATA. Back-to-back accepts give one write every 4 cycles.
- done is high the cycle after CHK is accepted. err and the cpu_hold update become visible in that same cycle.
- Minimum frame duration: 4(c+1)+2 accepted bytes; done follows one cycle after the last byte.
- Gaps in in_valid stall the FSM indefinitely. There is no timeout.
- Asserting reset_n low mid-frame forces all outputs to their reset values immediately. Partially written memory contents are left as they are.

## Test plan
- Single word:
  - Stimulus: start, then bytes 00 01 00 00 f8 f9.
  - Required: one mem_we with addr 0 and wdata 0xf8000001; done pulse; err = 0; cpu_hold falls with done.
- Bad checksum:
  - Stimulus: same frame with CHK = 00.
  - Required: the write to addr 0 still occurs; done = 1; err = 1; cpu_hold stays 1. A following good frame clears err and releases cpu_hold.
- Full image:
  - Stimulus: count 7f, 512 data bytes where word i = 0x8b1f0000 + i.
  - Required: 128 writes at addresses 0..127 in order, one every 4 cycles, correct data, no write after addr 127.
- Stalled stream:
  - Stimulus: in_valid toggled with random gaps across a 3-word frame.
  - Required: identical writes and checksum result to the gap-free run.
- Start while busy:
  - Stimulus: start pulsed during DATA.
  - Required: no restart; the word index continues; the frame completes normally.
- Reset mid-frame:
  - Stimulus: reset_n asserted low after 2 words.
  - Required: all outputs return to reset values; the next start and a full frame load correctly from addr 0.
